// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment scanner: active-low glyphs {g,f,e,d,c,b,a},
// off patterns and the digit-index width.
package seven_seg_pkg;

  localparam int IDX_W = 2;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [3:0] AN_OFF  = 4'b1111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

endpackage

// File: rtl/seven_seg_scanner_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_pat
);

  always_comb begin
    seg_pat = SEG_OFF;
    case (nibble)
      4'h0: seg_pat = GLYPH_0;
      4'h1: seg_pat = GLYPH_1;
      4'h2: seg_pat = GLYPH_2;
      4'h3: seg_pat = GLYPH_3;
      4'h4: seg_pat = GLYPH_4;
      4'h5: seg_pat = GLYPH_5;
      4'h6: seg_pat = GLYPH_6;
      4'h7: seg_pat = GLYPH_7;
      4'h8: seg_pat = GLYPH_8;
      4'h9: seg_pat = GLYPH_9;
      4'hA: seg_pat = GLYPH_A;
      4'hB: seg_pat = GLYPH_B;
      4'hC: seg_pat = GLYPH_C;
      4'hD: seg_pat = GLYPH_D;
      4'hE: seg_pat = GLYPH_E;
      default: seg_pat = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode display scanner: latches value/dp once per frame, multiplexes
// digits with leading-zero blanking, decimal point and a global blank.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_COUNT = 100000,
  parameter int DP_DIGIT      = 2,
  parameter int LZ_BLANK      = 1
) (
  input  logic        clk100Mhz,
  input  logic        rst,
  input  logic [15:0] display_value,
  input  logic        dp_in,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_tick
);

  localparam int CNT_W = (REFRESH_COUNT > 2) ? $clog2(REFRESH_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_COUNT - 1);
  localparam logic [IDX_W-1:0] DP_IDX   = IDX_W'(DP_DIGIT);

  logic [CNT_W-1:0] cnt_p0;
  logic [IDX_W-1:0] idx_p0;
  logic [15:0]      val_p0;
  logic             dp_p0;
  logic             init_pending;

  logic             wrap;
  logic             latch_evt;
  logic [3:0]       nibble;
  logic [6:0]       glyph;
  logic             lz_off;
  logic [3:0]       an_next;
  logic [6:0]       seg_next;
  logic             dp_next;

  // A digit is a leading zero when it and every digit above it hold zero.
  function automatic logic digit_blanked(input logic [IDX_W-1:0] k,
                                         input logic [15:0] v,
                                         input logic p);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (d >= int'(k) && v[d*4 +: 4] != 4'h0) upper_zero = 1'b0;
    end
    return (LZ_BLANK != 0) && (k != '0) && !(p && k <= DP_IDX) && upper_zero;
  endfunction

  assign wrap      = (cnt_p0 == CNT_LAST);
  assign latch_evt = init_pending || (wrap && idx_p0 == IDX_W'(3));
  assign nibble    = val_p0[idx_p0*4 +: 4];

  seg_decoder u_dec (
    .nibble  (nibble),
    .seg_pat (glyph)
  );

  always_comb begin
    lz_off   = digit_blanked(idx_p0, val_p0, dp_p0);
    seg_next = lz_off ? SEG_OFF : glyph;
    an_next  = (lz_off || blank) ? AN_OFF : ~(4'b0001 << idx_p0);
    dp_next  = !((idx_p0 == DP_IDX) && dp_p0 && !blank);
  end

  // Scan state and frame latch; pins register from the current index and latched data.
  always_ff @(posedge clk100Mhz) begin
    if (rst) begin
      cnt_p0       <= '0;
      idx_p0       <= '0;
      val_p0       <= 16'h0000;
      dp_p0        <= 1'b0;
      init_pending <= 1'b1;
      frame_tick   <= 1'b0;
      an           <= AN_OFF;
      seg          <= SEG_OFF;
      dp_n         <= 1'b1;
    end else begin
      cnt_p0 <= wrap ? '0 : cnt_p0 + 1'b1;
      if (wrap) idx_p0 <= idx_p0 + 1'b1;
      if (latch_evt) begin
        val_p0       <= display_value;
        dp_p0        <= dp_in;
        init_pending <= 1'b0;
      end
      frame_tick <= latch_evt;
      an         <= an_next;
      seg        <= seg_next;
      dp_n       <= dp_next;
    end
  end

endmodule
